// File: rtl/phys_reg_file_if.sv
// Bundles the writeback, rename-alloc, read-port and wakeup signals of phys_reg_file.
interface phys_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int PIDX_W = 6
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_dst_val;
  logic [PIDX_W-1:0] ex_dst_index;
  logic              alloc_valid;
  logic [PIDX_W-1:0] alloc_index;
  logic              rd0_en;
  logic [PIDX_W-1:0] rd0_index;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_ready;
  logic              rd1_en;
  logic [PIDX_W-1:0] rd1_index;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_ready;
  logic              wakeup_valid;
  logic [PIDX_W-1:0] wakeup_index;

  modport master (
    output ex_valid, ex_dst_val, ex_dst_index, alloc_valid, alloc_index,
           rd0_en, rd0_index, rd1_en, rd1_index,
    input  rd0_data, rd0_ready, rd1_data, rd1_ready, wakeup_valid, wakeup_index
  );

  modport slave (
    input  ex_valid, ex_dst_val, ex_dst_index, alloc_valid, alloc_index,
           rd0_en, rd0_index, rd1_en, rd1_index,
    output rd0_data, rd0_ready, rd1_data, rd1_ready, wakeup_valid, wakeup_index
  );
endinterface

// File: rtl/phys_reg_file.sv
// Physical register file with ready bits, two registered read ports and a wakeup strobe.
// Define PRF_BYPASS_EN to forward a same-cycle writeback into the read ports.
module phys_reg_file #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int PIDX_W    = $clog2(NUM_PREGS)
) (
  input logic           clk,
  input logic           rst,
  phys_reg_file_if.slave bus
);

  logic [DATA_W-1:0]    regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready;

  logic              wr_en;
  logic              alloc_en;
  logic [DATA_W-1:0] rd0_val;
  logic              rd0_rdy;
  logic [DATA_W-1:0] rd1_val;
  logic              rd1_rdy;

  // Preg 0 is never written or allocated, so it stays at value 0 / ready 1.
  assign wr_en    = bus.ex_valid    && (bus.ex_dst_index != '0);
  assign alloc_en = bus.alloc_valid && (bus.alloc_index  != '0);

  always_comb begin
    rd0_val = regs[bus.rd0_index];
    rd0_rdy = ready[bus.rd0_index];
`ifdef PRF_BYPASS_EN
    if (wr_en && (bus.ex_dst_index == bus.rd0_index)) begin
      rd0_val = bus.ex_dst_val;
      rd0_rdy = !(alloc_en && (bus.alloc_index == bus.rd0_index));
    end
`endif
  end

  always_comb begin
    rd1_val = regs[bus.rd1_index];
    rd1_rdy = ready[bus.rd1_index];
`ifdef PRF_BYPASS_EN
    if (wr_en && (bus.ex_dst_index == bus.rd1_index)) begin
      rd1_val = bus.ex_dst_val;
      rd1_rdy = !(alloc_en && (bus.alloc_index == bus.rd1_index));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs             <= '{default: '0};
      ready            <= '1;
      bus.rd0_data     <= '0;
      bus.rd0_ready    <= 1'b1;
      bus.rd1_data     <= '0;
      bus.rd1_ready    <= 1'b1;
      bus.wakeup_valid <= 1'b0;
      bus.wakeup_index <= '0;
    end else begin
      if (bus.rd0_en) begin
        bus.rd0_data  <= rd0_val;
        bus.rd0_ready <= rd0_rdy;
      end
      if (bus.rd1_en) begin
        bus.rd1_data  <= rd1_val;
        bus.rd1_ready <= rd1_rdy;
      end

      bus.wakeup_valid <= wr_en;
      if (wr_en) bus.wakeup_index <= bus.ex_dst_index;

      if (wr_en) begin
        regs[bus.ex_dst_index]  <= bus.ex_dst_val;
        ready[bus.ex_dst_index] <= 1'b1;
      end
      // Alloc is assigned last so it wins over a same-index write.
      if (alloc_en) ready[bus.alloc_index] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phys_reg_file.sv
// Randomized and directed self-checking bench for phys_reg_file against an array model.
module tb_phys_reg_file;
  localparam int NP = 64;
  localparam int DW = 32;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_file_if #(.DATA_W(DW), .PIDX_W(PW)) bus();

  phys_reg_file #(.NUM_PREGS(NP), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: value/ready arrays plus the expected registered outputs.
  logic [31:0]   m_val [NP];
  bit            m_rdy [NP];
  logic [31:0]   e_d0, e_d1;
  bit            e_r0, e_r1, e_wv;
  logic [PW-1:0] e_wi;
  logic [32:0]   tmp;

  function automatic logic [32:0] mread(input logic [PW-1:0] idx);
    if (idx == 0) return {1'b1, 32'h0};
`ifdef PRF_BYPASS_EN
    if (bus.ex_valid && bus.ex_dst_index == idx)
      return {!(bus.alloc_valid && bus.alloc_index == idx), bus.ex_dst_val};
`endif
    return {m_rdy[idx], m_val[idx]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        m_val[i] = '0;
        m_rdy[i] = 1'b1;
      end
      e_d0 = '0; e_r0 = 1'b1;
      e_d1 = '0; e_r1 = 1'b1;
      e_wv = 1'b0; e_wi = '0;
    end else begin
      if (bus.rd0_en) begin tmp = mread(bus.rd0_index); e_r0 = tmp[32]; e_d0 = tmp[31:0]; end
      if (bus.rd1_en) begin tmp = mread(bus.rd1_index); e_r1 = tmp[32]; e_d1 = tmp[31:0]; end
      e_wv = bus.ex_valid && bus.ex_dst_index != 0;
      if (e_wv) e_wi = bus.ex_dst_index;
      if (e_wv) begin
        m_val[bus.ex_dst_index] = bus.ex_dst_val;
        m_rdy[bus.ex_dst_index] = 1'b1;
      end
      if (bus.alloc_valid && bus.alloc_index != 0) m_rdy[bus.alloc_index] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("rd0_data", bus.rd0_data, e_d0);
      check("rd0_ready", {31'b0, bus.rd0_ready}, {31'b0, e_r0});
      check("rd1_data", bus.rd1_data, e_d1);
      check("rd1_ready", {31'b0, bus.rd1_ready}, {31'b0, e_r1});
      check("wakeup_valid", {31'b0, bus.wakeup_valid}, {31'b0, e_wv});
      check("wakeup_index", {26'b0, bus.wakeup_index}, {26'b0, e_wi});
    end
  end

  task automatic idle();
    bus.ex_valid = 1'b0; bus.ex_dst_val = '0; bus.ex_dst_index = '0;
    bus.alloc_valid = 1'b0; bus.alloc_index = '0;
    bus.rd0_en = 1'b0; bus.rd0_index = '0;
    bus.rd1_en = 1'b0; bus.rd1_index = '0;
  endtask

  task automatic wr(input logic [PW-1:0] idx, input logic [31:0] val);
    bus.ex_valid = 1'b1; bus.ex_dst_index = idx; bus.ex_dst_val = val;
  endtask

  task automatic rd0(input logic [PW-1:0] idx);
    bus.rd0_en = 1'b1; bus.rd0_index = idx;
  endtask

  function automatic logic [PW-1:0] pick();
    if ($urandom_range(0, 1) == 0) return PW'($urandom_range(0, 7));
    return PW'($urandom_range(0, NP - 1));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Reads right after reset
    rd0(5); bus.rd1_en = 1'b1; bus.rd1_index = 63;
    @(negedge clk);
    check("t1_rd0_data", bus.rd0_data, 32'h0);
    check("t1_rd0_ready", {31'b0, bus.rd0_ready}, 32'h1);
    check("t1_rd1_data", bus.rd1_data, 32'h0);
    check("t1_rd1_ready", {31'b0, bus.rd1_ready}, 32'h1);
    check("t1_wakeup_valid", {31'b0, bus.wakeup_valid}, 32'h0);

    // Alloc 7, read while pending, write, then read back
    idle(); bus.alloc_valid = 1'b1; bus.alloc_index = 7;
    @(negedge clk);
    idle(); rd0(7);
    @(negedge clk);
    check("t2_pending_ready", {31'b0, bus.rd0_ready}, 32'h0);
    idle(); wr(7, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_wakeup_valid", {31'b0, bus.wakeup_valid}, 32'h1);
    check("t2_wakeup_index", {26'b0, bus.wakeup_index}, 32'd7);
    idle(); rd0(7);
    @(negedge clk);
    check("t2_rd_data", bus.rd0_data, 32'hDEADBEEF);
    check("t2_rd_ready", {31'b0, bus.rd0_ready}, 32'h1);
    check("t2_wakeup_clear", {31'b0, bus.wakeup_valid}, 32'h0);

    // Preg 0 ignores writes
    idle(); wr(0, 32'h12345678);
    @(negedge clk);
    check("t3_no_wakeup", {31'b0, bus.wakeup_valid}, 32'h0);
    idle(); rd0(0);
    @(negedge clk);
    check("t3_rd_data", bus.rd0_data, 32'h0);
    check("t3_rd_ready", {31'b0, bus.rd0_ready}, 32'h1);

    // Same-cycle write and read of preg 9
    idle(); wr(9, 32'hA5A5A5A5); rd0(9);
    @(negedge clk);
`ifdef PRF_BYPASS_EN
    check("t4_same_data", bus.rd0_data, 32'hA5A5A5A5);
`else
    check("t4_same_data", bus.rd0_data, 32'h0);
`endif
    check("t4_same_ready", {31'b0, bus.rd0_ready}, 32'h1);
    idle(); rd0(9);
    @(negedge clk);
    check("t4_next_data", bus.rd0_data, 32'hA5A5A5A5);

    // Same-cycle alloc and write of preg 12
    idle(); wr(12, 32'h1); bus.alloc_valid = 1'b1; bus.alloc_index = 12;
    @(negedge clk);
    check("t5_wakeup_valid", {31'b0, bus.wakeup_valid}, 32'h1);
    check("t5_wakeup_index", {26'b0, bus.wakeup_index}, 32'd12);
    idle(); rd0(12);
    @(negedge clk);
    check("t5_rd_data", bus.rd0_data, 32'h1);
    check("t5_rd_ready", {31'b0, bus.rd0_ready}, 32'h0);

    // Back-to-back writes, reset lands on the third
    idle(); wr(3, 32'h33);
    @(negedge clk);
    check("t6_wake3", {26'b0, bus.wakeup_index}, 32'd3);
    check("t6_wake3_valid", {31'b0, bus.wakeup_valid}, 32'h1);
    wr(4, 32'h44);
    @(negedge clk);
    check("t6_wake4", {26'b0, bus.wakeup_index}, 32'd4);
    check("t6_wake4_valid", {31'b0, bus.wakeup_valid}, 32'h1);
    wr(5, 32'h55); rst = 1'b1;
    @(negedge clk);
    check("t6_no_wake5", {31'b0, bus.wakeup_valid}, 32'h0);
    rst = 1'b0; idle(); rd0(3);
    @(negedge clk);
    check("t6_rd3_data", bus.rd0_data, 32'h0);
    check("t6_rd3_ready", {31'b0, bus.rd0_ready}, 32'h1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.ex_valid = $urandom_range(0, 2) != 0;
      bus.ex_dst_index = pick();
      bus.ex_dst_val = $urandom;
      bus.alloc_valid = $urandom_range(0, 2) == 0;
      bus.alloc_index = pick();
      bus.rd0_en = $urandom_range(0, 3) != 0;
      bus.rd0_index = ($urandom_range(0, 1) == 0) ? bus.ex_dst_index : pick();
      bus.rd1_en = $urandom_range(0, 3) != 0;
      bus.rd1_index = ($urandom_range(0, 1) == 0) ? bus.rd0_index : pick();
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phys_reg_file.md
Name: phys_reg_file

Overview:
- Physical register file that consumes the Execute result bus (ex_valid, ex_dst_val, ex_dst_index) and holds NUM_PREGS 32-bit values plus one ready bit per register.
- Rename clears ready bits on allocation. Issue reads operands through two registered read ports.
- A one-cycle-delayed wakeup broadcast tells the scheduler which register just became ready.

Parameters:
- NUM_PREGS, 64, number of physical registers; power of two, at least 4.
- DATA_W, 32, register width; must match ex_dst_val.
- PIDX_W, $clog2(NUM_PREGS), physical index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  Execute writeback valid.
- ex_dst_val  in  DATA_W  writeback value.
- ex_dst_index  in  PIDX_W  writeback destination preg.
- alloc_valid  in  1  rename allocates a destination preg this cycle.
- alloc_index  in  PIDX_W  preg being allocated.
- rd0_en  in  1  read request, port 0.
- rd0_index  in  PIDX_W  read index, port 0.
- rd0_data  out  DATA_W  read data, port 0; one cycle after rd0_en.
- rd0_ready  out  1  ready bit of rd0_index, same timing as rd0_data.
- rd1_en, rd1_index, rd1_data, rd1_ready  same as port 0, for port 1.
- wakeup_valid  out  1  registered wakeup strobe.
- wakeup_index  out  PIDX_W  preg that became ready.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - all registers = 0; all ready bits = 1 (architectural mapping is valid at boot).
  - rd0_data = rd1_data = 0; rd0_ready = rd1_ready = 1.
  - wakeup_valid = 0; wakeup_index = 0.
  - Any in-flight read or wakeup is discarded.
  - Writes and allocs presented in a cycle where rst is high are ignored.
- Preg 0 is hardwired zero:
  - reads always return data 0, ready 1.
  - writes to index 0 are dropped and produce no wakeup.
  - alloc of index 0 is ignored.
- Write: when ex_valid is high and ex_dst_index != 0, at the edge regs[idx] <= ex_dst_val and ready[idx] <= 1.
- Alloc: when alloc_valid is high and alloc_index != 0, at the edge ready[idx] <= 0. The value is untouched.
- Write and alloc to the same index in the same cycle:
  - value is written; ready ends at 0 (alloc wins).
  - wakeup is still issued.
- Read: when rdN_en is high at edge T, rdN_data and rdN_ready reflect rdN_index at T+1 (1-cycle latency).
  - When rdN_en is low, rdN_data and rdN_ready hold their previous values.
  - Both ports may read the same index in the same cycle.
- Read and write to the same index in the same cycle: result depends on PRF_BYPASS_EN (see Optional Feature).
- Read of an index allocated in the same cycle returns the pre-alloc ready bit.
- Wakeup: on edge T, if ex_valid is high and ex_dst_index != 0, then wakeup_valid = 1 and wakeup_index = ex_dst_index from T+1 until the next edge. Otherwise wakeup_valid = 0 and wakeup_index holds.
- Back-to-back writes produce back-to-back wakeups, one per cycle with no gap.
- Indices are always in range; there is no wrap handling.
- Only one write port exists; multi-unit arbitration is done upstream.

Optional Feature:
- Macro: PRF_BYPASS_EN.
- Defined: a read captured in the same cycle as a write to the same nonzero index returns the new ex_dst_val with ready = 1. If an alloc to that index also occurs in that cycle, ready = 0.
- Undefined: the read samples the array before the write. It returns the old value and old ready bit; the new value is visible to reads issued from the next cycle.
- Wakeup timing is identical in both builds.

Test Plan:
- Reset, then rd0_en with index 5 and rd1_en with index 63 -> next cycle both data = 0, both ready = 1; wakeup_valid = 0.
- alloc preg 7; next cycle write 0xDEADBEEF to 7; next cycle read 7:
  - the cycle after the write shows wakeup_valid = 1, wakeup_index = 7;
  - the read returns 0xDEADBEEF, ready = 1;
  - a read issued between alloc and write returns ready = 0.
- Write 0x12345678 to preg 0, then read 0 -> data 0, ready 1, wakeup_valid stays 0.
- Write 0xA5A5A5A5 to preg 9 and read 9 in the same cycle -> with PRF_BYPASS_EN: 0xA5A5A5A5, ready 1; without: prior value, prior ready bit. A read in the following cycle returns 0xA5A5A5A5 in both builds.
- Same-cycle alloc and write to preg 12 with value 0x1 -> read next cycle gives data 0x1, ready 0; wakeup_valid = 1, wakeup_index = 12.
- Writes to pregs 3, 4, 5 in consecutive cycles, with rst asserted in the third cycle -> wakeups for 3 and 4 appear, no wakeup for 5; after reset, preg 3 reads 0, ready 1.
